// File: rtl/cpu_pkg.sv
// Shared definitions for the bit-serial CPU front end.
//   INST_W     : instruction width in bits
//   OPC_W      : opcode field width; the opcode occupies bits [OPC_MSB:OPC_LSB]
//   state_t    : instruction loader state encoding
package cpu_pkg;

   localparam int unsigned INST_W  = 12;
   localparam int unsigned OPC_W   = 4;
   localparam int unsigned OPC_LSB = 0;
   localparam int unsigned OPC_MSB = OPC_LSB + OPC_W - 1;

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_FULL   = 2'd1,
      ST_ISSUED = 2'd2
   } state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin plus rising-edge detect.
//   clk, rst_n : clock, async active-low reset
//   d          : asynchronous input pin
//   rise_c     : high for one cycle when the synchronized level goes 0->1
module sync_edge #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise_c
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   // Synchronizer chain and edge-detect history flop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign rise_c = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/instr_loader.sv
// Instruction loader / issue controller: shifts a serial instruction in
// LSB-first, holds it for issue on a run-button edge, and rotates the operand
// to stream the immediate bit by bit.
//   clk, rst_n         : clock, async active-low reset
//   ser_data, ser_clk  : asynchronous serial data and bit strobe
//   btn                : asynchronous run button (level)
//   exec_done          : executor finished, return to loading
//   imm_shift_en       : rotate operand one bit toward LSB
//   opcode, operand    : current instruction fields
//   imm_bit            : operand[0]
//   inst_done          : full instruction held
//   btn_edge           : one-cycle issue pulse
//   err_overrun        : sticky, strobe/button arrived when not acceptable
module instr_loader
   import cpu_pkg::*;
#(
   parameter int unsigned INST_W      = cpu_pkg::INST_W,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ser_data,
   input  logic                    ser_clk,
   input  logic                    btn,
   input  logic                    exec_done,
   input  logic                    imm_shift_en,
   output logic [OPC_W-1:0]        opcode,
   output logic [INST_W-OPC_W-1:0] operand,
   output logic                    imm_bit,
   output logic                    inst_done,
   output logic                    btn_edge,
   output logic                    err_overrun
);

   localparam int unsigned CNT_W = $clog2(INST_W + 1);

   state_t              state_q, state_d;
   logic [INST_W-1:0]   inst_q, inst_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                btn_edge_d, inst_done_d, err_d;
   logic [SYNC_STAGES-1:0] data_sync_q;
   logic                data_bit;
   logic                ser_rise_c, btn_rise_c;

   sync_edge #(.STAGES(SYNC_STAGES)) u_ser_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .d      (ser_clk),
      .rise_c (ser_rise_c)
   );

   sync_edge #(.STAGES(SYNC_STAGES)) u_btn_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .d      (btn),
      .rise_c (btn_rise_c)
   );

   // Plain synchronizer for the data pin, same depth as the strobe path
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) data_sync_q <= '0;
      else        data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ser_data};
   end

   assign data_bit = data_sync_q[SYNC_STAGES-1];

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_LOAD;
         inst_q      <= '0;
         cnt_q       <= '0;
         btn_edge    <= 1'b0;
         inst_done   <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         state_q     <= state_d;
         inst_q      <= inst_d;
         cnt_q       <= cnt_d;
         btn_edge    <= btn_edge_d;
         inst_done   <= inst_done_d;
         err_overrun <= err_d;
      end
   end

   // Next-state and register update logic
   always_comb begin
      state_d    = state_q;
      inst_d     = inst_q;
      cnt_d      = cnt_q;
      btn_edge_d = 1'b0;
      err_d      = err_overrun;

      unique case (state_q)
         ST_LOAD: begin
            if (ser_rise_c) begin
               inst_d = {data_bit, inst_q[INST_W-1:1]};
               if (cnt_q == CNT_W'(INST_W - 1)) begin
                  cnt_d   = '0;
                  state_d = ST_FULL;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_FULL: begin
            if (ser_rise_c) err_d = 1'b1;
            // Move on as the issue pulse ends so it lasts exactly one cycle
            if (btn_edge)        state_d    = ST_ISSUED;
            else if (btn_rise_c) btn_edge_d = 1'b1;
         end
         ST_ISSUED: begin
            if (ser_rise_c || btn_rise_c) err_d = 1'b1;
            if (imm_shift_en)
               inst_d[INST_W-1:OPC_W] = {inst_q[OPC_W], inst_q[INST_W-1:OPC_W+1]};
            if (exec_done) begin
               state_d = ST_LOAD;
               cnt_d   = '0;
            end
         end
         default: state_d = ST_LOAD;
      endcase

      inst_done_d = (state_d != ST_LOAD);
   end

   assign opcode  = inst_q[OPC_W-1:0];
   assign operand = inst_q[INST_W-1:OPC_W];
   assign imm_bit = inst_q[OPC_W];

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed vector table, a cycle-level
// latency sequence, then randomized operations against a transaction model.
module tb_instr_loader;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ser_data = 1'b0, ser_clk = 1'b0, btn = 1'b0;
   logic       exec_done = 1'b0, imm_shift_en = 1'b0;
   logic [3:0] opcode;
   logic [7:0] operand;
   logic       imm_bit, inst_done, btn_edge, err_overrun;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   instr_loader #(.INST_W(12), .SYNC_STAGES(2)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ser_data     (ser_data),
      .ser_clk      (ser_clk),
      .btn          (btn),
      .exec_done    (exec_done),
      .imm_shift_en (imm_shift_en),
      .opcode       (opcode),
      .operand      (operand),
      .imm_bit      (imm_bit),
      .inst_done    (inst_done),
      .btn_edge     (btn_edge),
      .err_overrun  (err_overrun)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send_bit(input logic b);
      ser_data = b;
      tick();
      ser_clk = 1'b1;
      ticks(4);
      ser_clk = 1'b0;
      ticks(4);
   endtask

   task automatic send_bits(input logic [11:0] v, input int n);
      for (int i = 0; i < n; i++) send_bit(v[i]);
   endtask

   task automatic press(input int hold, output int pulses);
      pulses = 0;
      btn = 1'b1;
      for (int i = 0; i < hold; i++) begin
         tick();
         if (btn_edge) pulses++;
      end
      btn = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (btn_edge) pulses++;
      end
   endtask

   // seen[i] is imm_bit just before the i-th shifting edge
   task automatic shift(input int n, output logic [15:0] seen);
      seen = '0;
      imm_shift_en = 1'b1;
      for (int i = 0; i < n; i++) begin
         seen[i] = imm_bit;
         tick();
      end
      imm_shift_en = 1'b0;
      ticks(1);
   endtask

   task automatic exec_pulse();
      exec_done = 1'b1;
      tick();
      exec_done = 1'b0;
      ticks(2);
   endtask

   // Strobe whose synchronized edge lands on the same cycle as exec_done
   task automatic exec_strobe(input logic b);
      ser_data = b;
      tick();
      ser_clk = 1'b1;
      ticks(2);
      exec_done = 1'b1;
      tick();
      exec_done = 1'b0;
      ticks(3);
      ser_clk = 1'b0;
      ticks(4);
   endtask

   task automatic assert_reset();
      rst_n = 1'b0;
      #2;
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
      ticks(2);
   endtask

   typedef enum int {K_RESET, K_BITS, K_BTN, K_SHIFT, K_EXEC, K_EXEC_STROBE} kind_t;

   typedef struct {
      kind_t       kind;
      logic [11:0] arg;
      int          n;
      logic [3:0]  e_opc;
      logic [7:0]  e_opr;
      logic        e_done;
      logic        e_err;
      int          e_pulses;
      logic [7:0]  e_seq;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(kind_t k, logic [11:0] a, int n, logic [3:0] opc,
                               logic [7:0] opr, logic done, logic err, int pulses,
                               logic [7:0] seq);
      vec_t v;
      v.kind = k; v.arg = a; v.n = n; v.e_opc = opc; v.e_opr = opr;
      v.e_done = done; v.e_err = err; v.e_pulses = pulses; v.e_seq = seq;
      return v;
   endfunction

   // Transaction-level reference model
   logic [11:0] m_reg;
   int          m_cnt;
   int          m_phase;  // 0 loading, 1 full, 2 issued
   logic        m_err;

   task automatic model_reset();
      m_reg = '0; m_cnt = 0; m_phase = 0; m_err = 1'b0;
   endtask

   task automatic model_bit(input logic b);
      if (m_phase == 0) begin
         m_reg = {b, m_reg[11:1]};
         m_cnt++;
         if (m_cnt == 12) begin
            m_phase = 1;
            m_cnt   = 0;
         end
      end else begin
         m_err = 1'b1;
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_opc"},  32'(opcode),      32'(m_reg[3:0]));
      chk({tag, "_opr"},  32'(operand),     32'(m_reg[11:4]));
      chk({tag, "_imm"},  32'(imm_bit),     32'(m_reg[4]));
      chk({tag, "_done"}, 32'(inst_done),   32'(m_phase != 0));
      chk({tag, "_err"},  32'(err_overrun), 32'(m_err));
   endtask

   initial begin
      int          pulses;
      logic [15:0] seen;

      // Directed vectors
      vecs.push_back(mk(K_RESET,       12'h000,   0, 4'h0, 8'h00, 0, 0, 0, 8'h00));
      vecs.push_back(mk(K_BITS,        12'hA58,  12, 4'h8, 8'hA5, 1, 0, 0, 8'h00));
      vecs.push_back(mk(K_BTN,         12'h000, 100, 4'h8, 8'hA5, 1, 0, 1, 8'h00));
      vecs.push_back(mk(K_SHIFT,       12'h000,   8, 4'h8, 8'hA5, 1, 0, 0, 8'hA5));
      vecs.push_back(mk(K_EXEC_STROBE, 12'h001,   0, 4'h8, 8'hA5, 0, 1, 0, 8'h00));
      vecs.push_back(mk(K_RESET,       12'h000,   0, 4'h0, 8'h00, 0, 0, 0, 8'h00));
      vecs.push_back(mk(K_BITS,        12'h012,  12, 4'h2, 8'h01, 1, 0, 0, 8'h00));
      vecs.push_back(mk(K_BITS,        12'h001,   1, 4'h2, 8'h01, 1, 1, 0, 8'h00));
      vecs.push_back(mk(K_BTN,         12'h000, 100, 4'h2, 8'h01, 1, 1, 1, 8'h00));
      vecs.push_back(mk(K_EXEC,        12'h000,   0, 4'h2, 8'h01, 0, 1, 0, 8'h00));
      vecs.push_back(mk(K_RESET,       12'h000,   0, 4'h0, 8'h00, 0, 0, 0, 8'h00));
      vecs.push_back(mk(K_BITS,        12'h013,   5, 4'h0, 8'h98, 0, 0, 0, 8'h00));
      vecs.push_back(mk(K_BTN,         12'h000, 100, 4'h0, 8'h98, 0, 0, 0, 8'h00));
      vecs.push_back(mk(K_BITS,        12'h07F,   7, 4'h3, 8'hFF, 1, 0, 0, 8'h00));
      vecs.push_back(mk(K_RESET,       12'h000,   0, 4'h0, 8'h00, 0, 0, 0, 8'h00));
      vecs.push_back(mk(K_BITS,        12'h055,   7, 4'h0, 8'hAA, 0, 0, 0, 8'h00));
      vecs.push_back(mk(K_RESET,       12'h000,   0, 4'h0, 8'h00, 0, 0, 0, 8'h00));
      vecs.push_back(mk(K_BITS,        12'hFFF,  11, 4'hE, 8'hFF, 0, 0, 0, 8'h00));
      vecs.push_back(mk(K_BITS,        12'h001,   1, 4'hF, 8'hFF, 1, 0, 0, 8'h00));

      ticks(2);
      foreach (vecs[i]) begin
         vec_t v;
         v = vecs[i];
         pulses = 0;
         seen   = '0;
         case (v.kind)
            K_RESET:       assert_reset();
            K_BITS:        send_bits(v.arg, v.n);
            K_BTN:         press(v.n, pulses);
            K_SHIFT:       shift(v.n, seen);
            K_EXEC:        exec_pulse();
            K_EXEC_STROBE: exec_strobe(v.arg[0]);
            default:       ;
         endcase
         chk($sformatf("v%0d_opc", i),  32'(opcode),      32'(v.e_opc));
         chk($sformatf("v%0d_opr", i),  32'(operand),     32'(v.e_opr));
         chk($sformatf("v%0d_imm", i),  32'(imm_bit),     32'(v.e_opr[0]));
         chk($sformatf("v%0d_done", i), 32'(inst_done),   32'(v.e_done));
         chk($sformatf("v%0d_err", i),  32'(err_overrun), 32'(v.e_err));
         chk($sformatf("v%0d_edge", i), 32'(btn_edge),    32'd0);
         if (v.kind == K_BTN)
            chk($sformatf("v%0d_pulses", i), 32'(pulses), 32'(v.e_pulses));
         if (v.kind == K_SHIFT)
            chk($sformatf("v%0d_immseq", i), 32'(seen[7:0]), 32'(v.e_seq));
         if (v.kind == K_RESET) release_reset();
      end

      // Cycle-exact latency: capture, inst_done, btn_edge and ISSUED entry
      assert_reset();
      release_reset();
      send_bits(12'h000, 11);
      ser_data = 1'b1;
      tick();
      ser_clk = 1'b1;
      tick();
      chk("lat_opr_e1",  32'(operand),   32'h00);
      chk("lat_done_e1", 32'(inst_done), 32'd0);
      tick();
      chk("lat_opr_e2",  32'(operand),   32'h00);
      chk("lat_done_e2", 32'(inst_done), 32'd0);
      tick();
      chk("lat_opr_e3",  32'(operand),   32'h80);
      chk("lat_done_e3", 32'(inst_done), 32'd1);
      ser_clk = 1'b0;
      ticks(4);
      btn = 1'b1;
      tick();
      chk("lat_edge_e1", 32'(btn_edge), 32'd0);
      tick();
      chk("lat_edge_e2", 32'(btn_edge), 32'd0);
      tick();
      chk("lat_edge_e3", 32'(btn_edge), 32'd1);
      tick();
      chk("lat_edge_e4", 32'(btn_edge), 32'd0);
      imm_shift_en = 1'b1;
      tick();
      imm_shift_en = 1'b0;
      chk("lat_issue_shift", 32'(operand), 32'h40);
      chk("lat_issue_imm",   32'(imm_bit), 32'd0);
      btn = 1'b0;
      ticks(4);
      exec_pulse();
      chk("lat_exec_done", 32'(inst_done), 32'd0);

      // Randomized operations against the model
      assert_reset();
      release_reset();
      model_reset();
      for (int k = 0; k < 300; k++) begin
         int          r;
         logic        b;
         int          n;
         int          exp_pulses;
         logic [15:0] exp_seen;
         string       tag;
         r   = int'($urandom_range(0, 99));
         b   = 1'($urandom);
         tag = $sformatf("r%0d", k);
         if (r < 55) begin
            send_bit(b);
            model_bit(b);
         end else if (r < 67) begin
            n = int'($urandom_range(4, 20));
            press(n, pulses);
            exp_pulses = 0;
            if (m_phase == 1) begin
               exp_pulses = 1;
               m_phase    = 2;
            end else if (m_phase == 2) begin
               m_err = 1'b1;
            end
            chk({tag, "_pulses"}, 32'(pulses), 32'(exp_pulses));
         end else if (r < 80) begin
            n = int'($urandom_range(1, 10));
            shift(n, seen);
            exp_seen = '0;
            for (int i = 0; i < n; i++) begin
               exp_seen[i] = m_reg[4];
               if (m_phase == 2) m_reg[11:4] = {m_reg[4], m_reg[11:5]};
            end
            chk({tag, "_immseq"}, 32'(seen), 32'(exp_seen));
         end else if (r < 92) begin
            exec_pulse();
            if (m_phase == 2) begin
               m_phase = 0;
               m_cnt   = 0;
            end
         end else if (r < 97) begin
            exec_strobe(b);
            if (m_phase == 2) begin
               m_err   = 1'b1;
               m_phase = 0;
               m_cnt   = 0;
            end else begin
               model_bit(b);
            end
         end else begin
            assert_reset();
            model_reset();
            check_model({tag, "_inrst"});
            release_reset();
         end
         check_model(tag);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
